// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per RUN cycle,
// full 2*WIDTH product split into result/result_hi with ALU-style status flags.
`ifndef ST_OVERFLOW
`define ST_OVERFLOW 0
`endif
`ifndef ST_CARRY
`define ST_CARRY 1
`endif
`ifndef ST_ZERO
`define ST_ZERO 2
`endif
`ifndef ST_NEG
`define ST_NEG 3
`endif

module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       statusOut,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [CW-1:0]      cnt;
   logic               last;
   logic [3:0]         status_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Handshake: start is a level sampled only in IDLE; done is a one-cycle
   // pulse in DONE, busy is high for exactly the WIDTH RUN cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // The multiplicand is shifted left once per cycle, so at bit index cnt it
   // already carries the shift-by-index weighting.
   assign last    = (cnt == CW'(WIDTH - 1));
   assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

   always_comb begin
      status_nxt               = '0;
      status_nxt[`ST_NEG]      = acc_nxt[WIDTH-1];
      status_nxt[`ST_ZERO]     = (acc_nxt == '0);
      status_nxt[`ST_CARRY]    = |acc_nxt[2*WIDTH-1:WIDTH];
      status_nxt[`ST_OVERFLOW] = 1'b0;
   end

   // Outputs are loaded on the final RUN edge so they are valid during DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand                <= '0;
         mplier               <= '0;
         acc                  <= '0;
         cnt                  <= '0;
         result               <= '0;
         result_hi            <= '0;
         statusOut            <= '0;
         statusOut[`ST_ZERO]  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, operand1};
                  mplier <= operand2;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  result    <= acc_nxt[WIDTH-1:0];
                  result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
                  statusOut <= status_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8: hand-computed products, latency,
// ignored mid-run start, asynchronous abort and back-to-back operation.
`ifndef ST_OVERFLOW
`define ST_OVERFLOW 0
`endif
`ifndef ST_CARRY
`define ST_CARRY 1
`endif
`ifndef ST_ZERO
`define ST_ZERO 2
`endif
`ifndef ST_NEG
`define ST_NEG 3
`endif

module tb_seq_multiplier;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] operand1;
   logic [W-1:0] operand2;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic [3:0]   statusOut;
   logic         busy;
   logic         done;

   int n_cmp;
   int n_mis;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .operand1  (operand1),
      .operand2  (operand2),
      .result    (result),
      .result_hi (result_hi),
      .statusOut (statusOut),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] mk_status(input logic neg, input logic zero, input logic carry);
      logic [3:0] s;
      s = '0;
      s[`ST_NEG]   = neg;
      s[`ST_ZERO]  = zero;
      s[`ST_CARRY] = carry;
      return s;
   endfunction

   // Called at a falling edge while the DUT is idle. The cycle in which start
   // is driven is cycle 0; done must appear in cycle W+1 (9 for W=8).
   task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                         input logic neg, input logic zero, input logic carry,
                         input bit disturb);
      logic [W-1:0] prev_lo;
      logic [W-1:0] prev_hi;
      int           cyc;
      int           n_done;
      prev_lo  = result;
      prev_hi  = result_hi;
      operand1 = a;
      operand2 = b;
      start    = 1'b1;
      cyc      = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (disturb && cyc == 3) begin
            operand1 = ~a;
            operand2 = ~b;
            start    = 1'b1;
         end
         if (disturb && cyc == 4) start = 1'b0;
         if (done) break;
         check("busy_in_run", busy, 1'b1);
         check("hold_lo_in_run", result, prev_lo);
         check("hold_hi_in_run", result_hi, prev_hi);
      end
      check("latency", cyc, W + 1);
      check("done_excl_busy", busy, 1'b0);
      check("result", result, exp_lo);
      check("result_hi", result_hi, exp_hi);
      check("status", statusOut, mk_status(neg, zero, carry));
      check("overflow", statusOut[`ST_OVERFLOW], 1'b0);
      n_done = 0;
      for (int i = 0; i < (disturb ? W + 4 : 1); i++) begin
         @(negedge clk);
         if (done) n_done++;
         check("idle_busy", busy, 1'b0);
      end
      check("extra_done", n_done, 0);
   endtask

   initial begin
      int n_done;
      n_cmp    = 0;
      n_mis    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      operand1 = '0;
      operand2 = '0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 8'h00);
      check("rst_result_hi", result_hi, 8'h00);
      check("rst_status", statusOut, mk_status(1'b0, 1'b1, 1'b0));
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);

      // start driven in the same cycle reset releases: first edge accepts it
      rst_n = 1'b1;
      do_mul(8'd12,  8'd10,  8'h78, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      do_mul(8'd200, 8'd3,   8'h58, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
      do_mul(8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
      do_mul(8'd16,  8'd8,   8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      do_mul(8'd0,   8'd255, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      // 13*11 = 143 = 0x8F; operands flipped and start pulsed mid-run
      do_mul(8'd13,  8'd11,  8'h8F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

      // abort: reset 4 cycles into the operation, between clock edges
      operand1 = 8'd9;
      operand2 = 8'd9;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_abort_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy_async", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_result", result, 8'h00);
      check("abort_result_hi", result_hi, 8'h00);
      check("abort_status", statusOut, mk_status(1'b0, 1'b1, 1'b0));
      n_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) n_done++;
      end
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("abort_no_done", n_done, 0);
      do_mul(8'd7, 8'd6, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // start held high: IDLE, 8x RUN, DONE repeating with period 10
      operand1 = 8'd5;
      operand2 = 8'd5;
      start    = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         check("held_done", done, (c % 10 == 9));
         check("held_busy", busy, ((c % 10) >= 1 && (c % 10) <= 8));
         if (c % 10 == 9) check("held_result", result, 8'd25);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
